// File: rtl/ifetch_pkg.sv
// Shared types and default widths for the instruction fetch slice.
// Ports: none (package only).
// Imported by instr_fetch and instr_mem; IFETCH_SKID_EN is consumed by instr_fetch.
package ifetch_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 16;

  typedef logic [ADDR_W_DEF-1:0]  addr_t;
  typedef logic [INSTR_W_DEF-1:0] instr_t;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_mem.sv
// Purpose: 1W/1R instruction RAM with a registered, enabled read port (block RAM style).
// Latency: read data valid one cycle after rd_en_i; a same-cycle write returns the old word.
// Backpressure: none; rd_data_o holds its value while rd_en_i is low.
// Ports: clk/rst, write port (wr_en_i, wr_addr_i, wr_data_i), read port (rd_en_i, rd_addr_i, rd_data_o).
module instr_mem
  import ifetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en_i,
  input  logic [ADDR_W-1:0]  wr_addr_i,
  input  logic [INSTR_W-1:0] wr_data_i,
  input  logic               rd_en_i,
  input  logic [ADDR_W-1:0]  rd_addr_i,
  output logic [INSTR_W-1:0] rd_data_o
);

  logic [INSTR_W-1:0] mem_q [2**ADDR_W];
  logic [INSTR_W-1:0] rd_data_q;

  // Storage is never cleared; only the output register has a reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instr_fetch.sv
// Purpose: owns program RAM, takes the download port, streams instructions in order to decode.
// Latency: 1 cycle issue->out_valid; redirect gives one bubble; restart at RESET_PC after download.
// Backpressure: out_valid & !out_ready holds outputs; IFETCH_SKID_EN adds a 2-entry skid (no release bubble).
// Ports: clk, rst; download (write, write_instruction_index, write_instruction);
//        redirect (redirect_valid, redirect_pc); output (out_valid, out_ready, out_instr, out_pc); loading.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int RESET_PC = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               write,
  input  logic [ADDR_W-1:0]  write_instruction_index,
  input  logic [INSTR_W-1:0] write_instruction,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               loading
);

  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  rd_pc_q;
  logic               rd_vld_q, rd_vld_d;
  logic [INSTR_W-1:0] rd_data;
  logic               redir, flush, can_issue, issue;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (write) begin
      state_d = LOAD;
    end else if (state_q == LOAD) begin
      state_d = RUN;
    end
  end

  always_comb begin
    loading = (state_q == LOAD);
  end

  // ---------------- fetch control ----------------
  // Download beats redirect; both drop whatever is held or in flight.
  assign redir = redirect_valid & ~write & (state_q == RUN);
  assign flush = write | redir;
  // The LOAD->RUN cycle issues RESET_PC because the slot was emptied by the download.
  // A redirect only reloads pc; the target is issued next cycle from an empty slot.
  assign issue = ~flush & can_issue;

  always_comb begin
    pc_d = pc_q;
    if (write) begin
      pc_d = RESET_ADDR;
    end else if (redir) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_ADDR;
      rd_vld_q <= 1'b0;
      rd_pc_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_vld_q <= rd_vld_d;
      if (issue) begin
        rd_pc_q <= pc_q;
      end
    end
  end

  instr_mem #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (write & ~rst),
    .wr_addr_i(write_instruction_index),
    .wr_data_i(write_instruction),
    .rd_en_i  (issue),
    .rd_addr_i(pc_q),
    .rd_data_o(rd_data)
  );

`ifdef IFETCH_SKID_EN
  // The RAM output register is the youngest word; anything decode has not
  // taken is moved into a 2-entry buffer whose head drives the outputs.
  logic [1:0]         sk_cnt_q;
  logic [ADDR_W-1:0]  sk_pc_q    [2];
  logic [INSTR_W-1:0] sk_instr_q [2];
  logic               head_sk, pop, pop_sk, push_sk, push_idx;
  logic [1:0]         occ_after;

  always_comb begin
    head_sk   = (sk_cnt_q != 2'd0);
    out_valid = head_sk | rd_vld_q;
    out_pc    = head_sk ? sk_pc_q[0]    : rd_pc_q;
    out_instr = head_sk ? sk_instr_q[0] : rd_data;
    pop       = out_valid & out_ready;
    pop_sk    = head_sk & pop;
    // The RAM word bypasses the buffer only when it is the head and gets taken.
    push_sk   = rd_vld_q & ~(pop & ~head_sk);
    push_idx  = sk_cnt_q[0] ^ pop_sk;
    // Words left after this edge; issuing is safe while at most one remains,
    // so buffer plus RAM register never exceed two.
    occ_after = sk_cnt_q + {1'b0, rd_vld_q} - {1'b0, pop};
    can_issue = (occ_after <= 2'd1);
  end

  assign rd_vld_d = issue;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      sk_cnt_q <= 2'd0;
    end else begin
      sk_cnt_q <= sk_cnt_q + {1'b0, push_sk} - {1'b0, pop_sk};
    end
  end

  always_ff @(posedge clk) begin
    if (pop_sk) begin
      sk_pc_q[0]    <= sk_pc_q[1];
      sk_instr_q[0] <= sk_instr_q[1];
    end
    // Placed after the shift so a pop+push into slot 0 keeps the new word.
    if (push_sk) begin
      sk_pc_q[push_idx]    <= rd_pc_q;
      sk_instr_q[push_idx] <= rd_data;
    end
  end
`else
  // Single output slot: the RAM output register itself. After a stall the
  // next read waits one cycle, so each release costs exactly one bubble.
  logic stalled_q;

  always_comb begin
    out_valid = rd_vld_q;
    out_pc    = rd_pc_q;
    out_instr = rd_data;
  end

  assign can_issue = ~rd_vld_q | (out_ready & ~stalled_q);
  assign rd_vld_d  = ~flush & (issue | (rd_vld_q & ~out_ready));

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      stalled_q <= 1'b0;
    end else begin
      stalled_q <= rd_vld_q & ~out_ready;
    end
  end
`endif

endmodule
